// File: rtl/gate_tester_if.sv
// Stimulus/response bundle between gate_tester, its controller and the gate under test.
// The master modport is the tester side. The slave modport is the controller and gate side.
// Purely structural; it holds no state.
interface gate_tester_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] observed;
  logic [3:0] fail_mask;

  modport master (
    input  start, c,
    output a, b, busy, done, pass, observed, fail_mask
  );

  modport slave (
    output start, c,
    input  a, b, busy, done, pass, observed, fail_mask
  );
endinterface

// File: rtl/gate_tester.sv
// Applies all four {a,b} vectors to a 2-input gate and checks c against EXPECTED.
// Latency: 4*(SETTLE_CYCLES+1) busy cycles, then a 1-cycle done pulse. All outputs are registered.
// Backpressure: none. start is honoured only in IDLE and is never queued.
// Optional macro GATE_TESTER_STICKY_FAIL_EN: fail_mask ORs across runs and only rst clears it.
module gate_tester #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] EXPECTED      = 4'b0001
) (
  input logic         clk,
  input logic         rst,
  gate_tester_if.master bus
);

  localparam logic [3:0] SETTLE = SETTLE_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] observed_q, observed_nxt;
  logic [3:0] fail_q, fail_nxt;
  logic       pass_q, pass_nxt;
  logic       a_q, b_q, busy_q, done_q;

  // Next-state logic: settle counting, sampling of c, and the verdict on the final vector.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    observed_nxt = observed_q;
    fail_nxt     = fail_q;
    pass_nxt     = pass_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt    = DRIVE;
          idx_nxt      = 2'd0;
          cnt_nxt      = 4'd0;
          observed_nxt = 4'd0;
`ifndef GATE_TESTER_STICKY_FAIL_EN
          fail_nxt     = 4'd0;
`endif
        end
      end
      DRIVE: begin
        if (cnt < SETTLE) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          observed_nxt[idx] = bus.c;
`ifdef GATE_TESTER_STICKY_FAIL_EN
          fail_nxt[idx] = fail_q[idx] | (bus.c != EXPECTED[idx]);
`else
          fail_nxt[idx] = (bus.c != EXPECTED[idx]);
`endif
          cnt_nxt = 4'd0;
          if (idx == 2'd3) begin
            // The verdict is registered with the last sample, so it is already valid in the done cycle.
            state_nxt = DONE;
            pass_nxt  = (observed_nxt == EXPECTED);
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs. Outputs are decoded from the next state, so no path runs from c to an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 4'd0;
      observed_q <= 4'd0;
      fail_q     <= 4'd0;
      pass_q     <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      observed_q <= observed_nxt;
      fail_q     <= fail_nxt;
      pass_q     <= pass_nxt;
      a_q        <= (state_nxt == DRIVE) ? idx_nxt[1] : 1'b0;
      b_q        <= (state_nxt == DRIVE) ? idx_nxt[0] : 1'b0;
      busy_q     <= (state_nxt == DRIVE);
      done_q     <= (state_nxt == DONE);
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.observed  = observed_q;
  assign bus.fail_mask = fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester. It runs a default instance against selectable gate models and an OR gate with SETTLE_CYCLES=3.
// Expected results come from a run table, plus hand sequences for ignored start, abort by rst, and settle timing.
// Each vector's c comes from a combinational gate model.
module tb_gate_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_tester_if bus0 ();
  gate_tester_if bus1 ();

  // Gate model modes: 0 ideal NOR, 1 stuck-at-0, 2 stuck-at-1, 3 OR.
  logic [1:0] mode0 = 2'd0;

  always_comb begin
    case (mode0)
      2'd0:    bus0.c = ~(bus0.a | bus0.b);
      2'd1:    bus0.c = 1'b0;
      2'd2:    bus0.c = 1'b1;
      default: bus0.c = bus0.a | bus0.b;
    endcase
  end

  assign bus1.c = bus1.a | bus1.b;

  gate_tester dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  gate_tester #(.SETTLE_CYCLES(3), .EXPECTED(4'b0001)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  int checks = 0;
  int errors = 0;
  logic [3:0] acc_fail = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one default-parameter test and checks its timing and results. If poke is set, start is pulsed again in busy cycle 3.
  task automatic run0(input string tag, input logic [1:0] mode, input logic [3:0] eo,
                      input logic [3:0] ef, input logic ep, input bit poke);
    int busy_n = 0;
    int done_n = 0;
    int done_at = 0;
    logic [3:0] o = 4'bx;
    logic [3:0] f = 4'bx;
    logic p = 1'bx;
    mode0 = mode;
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      bus0.start = (poke && k == 3);
      if (bus0.busy) busy_n++;
      if (bus0.done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = k;
          o = bus0.observed;
          f = bus0.fail_mask;
          p = bus0.pass;
        end
      end
    end
    bus0.start = 1'b0;
    chk({tag, " busy_cycles"}, busy_n, 8);
    chk({tag, " done_count"}, done_n, 1);
    chk({tag, " done_cycle"}, done_at, 9);
    chk({tag, " observed"}, {28'd0, o}, {28'd0, eo});
    chk({tag, " fail_mask"}, {28'd0, f}, {28'd0, ef});
    chk({tag, " pass"}, {31'd0, p}, {31'd0, ep});
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [3:0] obs;
    logic [3:0] fail;
    logic       pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int done_n;
    int busy_n;
    int done_at;
    logic [3:0] ef;

    tbl[0] = '{mode: 2'd0, obs: 4'b0001, fail: 4'b0000, pass: 1'b1};
    tbl[1] = '{mode: 2'd1, obs: 4'b0000, fail: 4'b0001, pass: 1'b0};
    tbl[2] = '{mode: 2'd0, obs: 4'b0001, fail: 4'b0000, pass: 1'b1};
    tbl[3] = '{mode: 2'd2, obs: 4'b1111, fail: 4'b1110, pass: 1'b0};
    tbl[4] = '{mode: 2'd0, obs: 4'b0001, fail: 4'b0000, pass: 1'b1};

    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst busy", bus0.busy, 0);
    chk("rst done", bus0.done, 0);
    chk("rst pass", bus0.pass, 0);
    chk("rst ab", {bus0.a, bus0.b}, 0);
    chk("rst observed", bus0.observed, 0);
    chk("rst fail_mask", bus0.fail_mask, 0);
    chk("rst1 busy", bus1.busy, 0);

    // Table of complete runs.
    for (int i = 0; i < 5; i++) begin
`ifdef GATE_TESTER_STICKY_FAIL_EN
      acc_fail = acc_fail | tbl[i].fail;
      ef = acc_fail;
`else
      ef = tbl[i].fail;
`endif
      run0($sformatf("run%0d", i), tbl[i].mode, tbl[i].obs, ef, tbl[i].pass, 1'b0);
    end

    // A start pulse during busy cycle 3 is ignored.
`ifdef GATE_TESTER_STICKY_FAIL_EN
    ef = acc_fail;
`else
    ef = 4'b0000;
`endif
    run0("poke", 2'd0, 4'b0001, ef, 1'b1, 1'b1);

    // Asserting rst in busy cycle 5 aborts the run. The previous run had left pass=1 and observed=0001.
    mode0 = 2'd0;
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus0.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_fail = 4'd0;
    chk("abort busy", bus0.busy, 0);
    chk("abort ab", {bus0.a, bus0.b}, 0);
    chk("abort observed", bus0.observed, 0);
    chk("abort pass", bus0.pass, 0);
    chk("abort fail_mask", bus0.fail_mask, 0);
    done_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) done_n++;
    end
    chk("abort stays idle", done_n, 0);
    run0("after_abort", 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0);

    // OR gate with SETTLE_CYCLES=3. Each vector is held 4 cycles and busy lasts 16 cycles.
    busy_n = 0;
    done_at = 0;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (bus1.busy) busy_n++;
      if (k <= 16) begin
        logic [4:0] v;
        v = 5'(k - 1);
        chk($sformatf("s3 ab cyc%0d", k), {30'd0, bus1.a, bus1.b}, {30'd0, v[3:2]});
      end
      if (bus1.done && done_at == 0) begin
        done_at = k;
        chk("s3 observed", bus1.observed, 4'b1110);
        chk("s3 fail_mask", bus1.fail_mask, 4'b1111);
        chk("s3 pass", bus1.pass, 0);
      end
    end
    chk("s3 busy_cycles", busy_n, 16);
    chk("s3 done_cycle", done_at, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
